// File: rtl/wave_gen_pkg.sv
// Shared types and constants for the command-driven waveform generator.
// Optional argument timeout is enabled with WAVE_GEN_TIMEOUT_EN.
package wave_gen_pkg;

   typedef enum logic [1:0] {
      WAVE_SAW_UP   = 2'd0,
      WAVE_TRI      = 2'd1,
      WAVE_SQUARE   = 2'd2,
      WAVE_SAW_DOWN = 2'd3
   } wave_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAVE_ARG,
      ST_STEP_HI,
      ST_STEP_LO
   } parse_t;

   localparam logic [1:0] CTRL_RUN   = 2'b01;
   localparam logic [1:0] CTRL_PAUSE = 2'b10;
   localparam logic [1:0] CTRL_STOP  = 2'b00;

   localparam logic [7:0] CMD_RUN   = 8'h73;
   localparam logic [7:0] CMD_PAUSE = 8'h70;
   localparam logic [7:0] CMD_STOP  = 8'h78;
   localparam logic [7:0] CMD_WAVE  = 8'h77;
   localparam logic [7:0] CMD_FREQ  = 8'h66;

   // ASCII '0'..'3' share this upper 6-bit prefix
   localparam logic [5:0] DIGIT_0_3 = 6'b001100;

endpackage

// File: rtl/wave_gen_ctrl_if.sv
// UART-command and DAC-side signal bundle for wave_gen_ctrl.
// Master drives Rx bytes and sample requests; slave is the generator.
interface wave_gen_ctrl_if #(
   parameter int DATA_W  = 10,
   parameter int PHASE_W = 16
);
   logic [7:0]         ipRxData;
   logic               ipRxValid;
   logic               ipSampleReq;
   logic [DATA_W-1:0]  opSample;
   logic [1:0]         opControl;
   logic [1:0]         opWave;
   logic [PHASE_W-1:0] opStep;
   logic               opCmdError;

   modport master (
      output ipRxData, ipRxValid, ipSampleReq,
      input  opSample, opControl, opWave, opStep, opCmdError
   );

   modport slave (
      input  ipRxData, ipRxValid, ipSampleReq,
      output opSample, opControl, opWave, opStep, opCmdError
   );
endinterface

// File: rtl/wave_shaper.sv
// Combinational phase-to-sample mapping for the four waveforms.
// Only the top DATA_W+1 phase bits matter, so only those are ported in.
module wave_shaper
   import wave_gen_pkg::*;
#(
   parameter int DATA_W  = 10,
   parameter int PHASE_W = 16
) (
   input  logic [PHASE_W-1:PHASE_W-1-DATA_W] phase,
   input  wave_t                             wave,
   output logic [DATA_W-1:0]                 sample
);
   logic              msb;
   logic [DATA_W-1:0] saw;
   logic [DATA_W-1:0] tval;
   logic [DATA_W-1:0] tri_v;

   assign msb   = phase[PHASE_W-1];
   assign saw   = phase[PHASE_W-1 -: DATA_W];
   assign tval  = phase[PHASE_W-2 -: DATA_W];
   assign tri_v = msb ? ~tval : tval;

   always_comb begin
      sample = saw;
      unique case (wave)
         WAVE_SAW_UP:   sample = saw;
         WAVE_TRI:      sample = tri_v;
         WAVE_SQUARE:   sample = msb ? '1 : '0;
         WAVE_SAW_DOWN: sample = ~saw;
      endcase
   end
endmodule

// File: rtl/wave_gen_ctrl.sv
// Byte-command parser, phase accumulator and registered DAC sample stage.
// Define WAVE_GEN_TIMEOUT_EN to abort stalled argument bytes.
module wave_gen_ctrl
   import wave_gen_pkg::*;
#(
   parameter int DATA_W         = 10,
   parameter int PHASE_W        = 16,
   parameter int STEP_DEFAULT   = 64,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input logic ipClk,
   input logic ipReset,
   wave_gen_ctrl_if.slave bus
);
   parse_t             state;
   logic [7:0]         step_hi;
   logic [15:0]        step_word;
   logic [PHASE_W-1:0] phase;
   logic [PHASE_W-1:0] step;
   logic [1:0]         ctrl;
   wave_t              wave;
   logic               err;
   logic [DATA_W-1:0]  sample;
   logic [DATA_W-1:0]  shaped;
   logic [7:0]         rx;

`ifdef WAVE_GEN_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;
`endif

   assign rx        = bus.ipRxData;
   assign step_word = {step_hi, rx};

   wave_shaper #(
      .DATA_W  (DATA_W),
      .PHASE_W (PHASE_W)
   ) u_shaper (
      .phase  (phase[PHASE_W-1 -: DATA_W+1]),
      .wave   (wave),
      .sample (shaped)
   );

   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         state   <= ST_IDLE;
         step_hi <= '0;
         phase   <= '0;
         step    <= PHASE_W'(STEP_DEFAULT);
         ctrl    <= CTRL_STOP;
         wave    <= WAVE_SAW_UP;
         err     <= 1'b0;
         sample  <= '0;
`ifdef WAVE_GEN_TIMEOUT_EN
         cnt     <= '0;
`endif
      end else begin
         err    <= 1'b0;
         sample <= shaped;
         // Uses the pre-command control and step; a stop below overrides
         if (bus.ipSampleReq && ctrl == CTRL_RUN)
            phase <= phase + step;
         if (bus.ipRxValid) begin
`ifdef WAVE_GEN_TIMEOUT_EN
            cnt <= '0;
`endif
            unique case (state)
               ST_IDLE: begin
                  unique case (1'b1)
                     rx == CMD_RUN:   ctrl <= CTRL_RUN;
                     rx == CMD_PAUSE: ctrl <= CTRL_PAUSE;
                     rx == CMD_STOP: begin
                        ctrl  <= CTRL_STOP;
                        phase <= '0;
                     end
                     rx == CMD_WAVE:  state <= ST_WAVE_ARG;
                     rx == CMD_FREQ:  state <= ST_STEP_HI;
                     default:         err <= 1'b1;
                  endcase
               end
               ST_WAVE_ARG: begin
                  if (rx[7:2] == DIGIT_0_3)
                     wave <= wave_t'(rx[1:0]);
                  else
                     err <= 1'b1;
                  state <= ST_IDLE;
               end
               ST_STEP_HI: begin
                  step_hi <= rx;
                  state   <= ST_STEP_LO;
               end
               ST_STEP_LO: begin
                  step  <= step_word[PHASE_W-1:0];
                  state <= ST_IDLE;
               end
            endcase
         end
`ifdef WAVE_GEN_TIMEOUT_EN
         else if (state != ST_IDLE) begin
            if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               cnt   <= '0;
               state <= ST_IDLE;
               err   <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
`endif
      end
   end

   assign bus.opSample   = sample;
   assign bus.opControl  = ctrl;
   assign bus.opWave     = wave;
   assign bus.opStep     = step;
   assign bus.opCmdError = err;
endmodule

// File: tb/tb_wave_gen_ctrl.sv
// Directed bench for wave_gen_ctrl.
// Timeout case needs WAVE_GEN_TIMEOUT_EN.
module tb_wave_gen_ctrl;
  import wave_gen_pkg::*;

  localparam int DATA_W  = 10;
  localparam int PHASE_W = 16;
  localparam int TO      = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wave_gen_ctrl_if #(
    .DATA_W  (DATA_W),
    .PHASE_W (PHASE_W)
  ) bus ();

  wave_gen_ctrl #(
    .DATA_W         (DATA_W),
    .PHASE_W        (PHASE_W),
    .STEP_DEFAULT   (64),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .ipClk   (clk),
    .ipReset (rst),
    .bus     (bus)
  );

  task automatic ok(bit c, string nm);
    checks++;
    if (!c) begin
      failures++;
      $display("FAIL %s t=%0t", nm, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.ipRxValid   = 1'b0;
    bus.ipSampleReq = 1'b0;
  endtask

  task automatic tx(logic [7:0] b);
    bus.ipRxData  = b;
    bus.ipRxValid = 1'b1;
    step();
  endtask

  task automatic req();
    bus.ipSampleReq = 1'b1;
    step();
  endtask

  initial begin
    bus.ipRxData    = 8'h00;
    bus.ipRxValid   = 1'b0;
    bus.ipSampleReq = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    ok(bus.opSample == 0, "rst_sample");
    ok(bus.opControl == 2'b00, "rst_ctrl");
    ok(bus.opWave == 2'd0, "rst_wave");
    ok(bus.opStep == 16'd64, "rst_step");
    ok(bus.opCmdError == 1'b0, "rst_err");

    tx(CMD_RUN);
    ok(bus.opControl == CTRL_RUN, "run_ctrl");
    repeat (4) req();
    step();
    ok(bus.opSample == 10'd4, "saw_256");

    tx(CMD_STOP);
    ok(bus.opControl == CTRL_STOP, "stop_ctrl");
    step();
    ok(bus.opSample == 10'd0, "stop_sample");

    tx(CMD_FREQ);
    tx(8'h40);
    tx(8'h00);
    ok(bus.opStep == 16'h4000, "step_4000");
    tx(CMD_RUN);
    req();
    req();
    ok(bus.opSample == 10'd256, "q_4000");
    req();
    ok(bus.opSample == 10'd512, "q_8000");
    step();
    ok(bus.opSample == 10'd768, "q_c000");

    tx(CMD_WAVE);
    tx(8'h31);
    ok(bus.opWave == 2'd1, "wave_tri");
    step();
    ok(bus.opSample == 10'd511, "tri_c000");

    tx(CMD_WAVE);
    tx(8'h37);
    ok(bus.opCmdError == 1'b1, "bad_digit_err");
    step();
    ok(bus.opCmdError == 1'b0, "err_one_cycle");
    ok(bus.opWave == 2'd1, "wave_kept");

    req();
    step();
    ok(bus.opSample == 10'd0, "wrap_tri_0");

    tx(CMD_PAUSE);
    ok(bus.opControl == CTRL_PAUSE, "pause_ctrl");
    repeat (5) req();
    step();
    ok(bus.opSample == 10'd0, "pause_hold");

    tx(CMD_WAVE);
    tx(8'h33);
    ok(bus.opWave == 2'd3, "wave_sawdn");
    step();
    ok(bus.opSample == 10'd1023, "sawdn_paused");

    tx(CMD_STOP);
    ok(bus.opControl == CTRL_STOP, "stop2_ctrl");
    step();
    ok(bus.opSample == 10'd1023, "sawdn_zero");

    tx(CMD_FREQ);
    tx(8'h12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ok(bus.opStep == 16'd64, "rst_mid_step");
    ok(bus.opWave == 2'd0, "rst_mid_wave");
    tx(CMD_RUN);
    ok(bus.opControl == CTRL_RUN, "post_rst_cmd");
    ok(bus.opStep == 16'd64, "post_rst_step");
    ok(bus.opCmdError == 1'b0, "post_rst_err");

    tx(8'h71);
    ok(bus.opCmdError == 1'b1, "unknown_cmd");
    ok(bus.opControl == CTRL_RUN, "unknown_keeps");

    bus.ipSampleReq = 1'b1;
    tx(CMD_PAUSE);
    ok(bus.opControl == CTRL_PAUSE, "simul_pause");
    step();
    ok(bus.opSample == 10'd1, "simul_req_runs");

    tx(CMD_RUN);
    bus.ipSampleReq = 1'b1;
    tx(CMD_STOP);
    ok(bus.opControl == CTRL_STOP, "stop_ctrl3");
    step();
    ok(bus.opSample == 10'd0, "stop_beats_req");

    tx(CMD_RUN);
    req();
    step();
    ok(bus.opSample == 10'd1, "pre_zero");
    tx(CMD_FREQ);
    tx(8'h00);
    tx(8'h00);
    ok(bus.opStep == 16'd0, "step_zero");
    req();
    req();
    step();
    ok(bus.opSample == 10'd1, "zero_frozen");

`ifdef WAVE_GEN_TIMEOUT_EN
    tx(CMD_WAVE);
    repeat (TO - 1) step();
    ok(bus.opCmdError == 1'b0, "to_early");
    step();
    ok(bus.opCmdError == 1'b1, "to_expire");
    step();
    ok(bus.opCmdError == 1'b0, "to_one_cycle");
    tx(8'h32);
    ok(bus.opCmdError == 1'b1, "to_then_cmd");
    ok(bus.opWave == 2'd0, "to_wave_kept");
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
